// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: none (types only); backpressure: n/a.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    KILL
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of fetch_entry_t with zero-latency head read and single-cycle flush.
// Latency: push visible at head next cycle; backpressure: caller must not push when full without a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, one outstanding imem request, buffers words, flushes on redirect (FETCH_PERF_CNT_EN adds counters).
// Latency: rvalid -> instr_valid +1 cycle, redirect -> new request +1 cycle; backpressure: requests stop while the buffer is full.
module fetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  fetch_entry_t    push_entry, head_entry;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  logic [XLEN-1:0] redirect_pc;
  logic            granted;
  logic            rsp_live;
  logic            rsp_pending;

  assign redirect_pc = redirect_target & ~XLEN'(3);
  assign imem_req    = (state_q == REQ) && (fifo_count < CW'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign granted     = imem_req && imem_gnt;
  assign rsp_live    = imem_rvalid && ((state_q == WAIT) || (state_q == KILL));

  // A response is still owed after this cycle if one was just granted or is outstanding and not returning now.
  assign rsp_pending = granted || (((state_q == WAIT) || (state_q == KILL)) && !imem_rvalid);

  assign instr_valid = !fifo_empty;
  assign fifo_pop    = instr_valid && instr_ready && !redirect;
  assign fifo_push   = (state_q == WAIT) && imem_rvalid && !redirect && (!fifo_full || fifo_pop);
  assign push_entry  = '{instr: imem_rdata, pc: req_pc_q};
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (granted) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
          state_d    = WAIT;
        end
      end
      WAIT, KILL: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      state_d    = rsp_pending ? KILL : REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .push_dat(push_entry),
    .pop     (fifo_pop),
    .flush   (redirect),
    .head_dat(head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // A redirect cycle costs one, plus every buffered entry and any response it drops.
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'b0, fifo_pop};
    perf_flushed_d = perf_flushed_q;
    if (redirect) begin
      perf_flushed_d = perf_flushed_q + 32'd1 + 32'(fifo_count) + {31'b0, rsp_live};
    end else if ((state_q == KILL) && imem_rvalid) begin
      perf_flushed_d = perf_flushed_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboarded instruction-memory model and a wrap-around PC instance.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, instr_pc, redirect_target;

  logic        w_req, w_gnt, w_rvalid, w_ivalid, w_ready, w_redirect;
  logic [31:0] w_addr, w_rdata, w_instr, w_ipc, w_target;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_target(redirect_target)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instr_valid(w_ivalid), .instr(w_instr), .instr_pc(w_ipc), .instr_ready(w_ready),
    .redirect(w_redirect), .redirect_target(w_target)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] hs_log[$];
  logic [31:0] gnt_log[$];
  logic [31:0] w_log[$];
  bit          hold_resp;
  int          drop_cnt;
  logic [31:0] wexp [3];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard the handshake, model memory grants/responses, sample 1 time unit after the edge.
  task automatic tick();
    logic        g, wg;
    logic [31:0] ga, wa;
    logic [63:0] e;
    if (instr_valid && instr_ready && !redirect) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e[63:32]);
        chk("sb_pc", instr_pc, e[31:0]);
      end
      hs_log.push_back(instr_pc);
    end
    if (redirect) exp_q.delete();
    g  = imem_req && imem_gnt;
    ga = imem_addr;
    wg = w_req && w_gnt;
    wa = w_addr;
    if (g) gnt_log.push_back(ga);
    if (wg && w_log.size() < 3) w_log.push_back(wa);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    w_rvalid    = wg;
    w_rdata     = wa;
    if (g) pend_q.push_back(ga);
    if (redirect) drop_cnt = pend_q.size();
    if (pend_q.size() != 0 && !hold_resp) begin
      ga          = pend_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(ga);
      if (drop_cnt > 0) drop_cnt--;
      else exp_q.push_back({mem_word(ga), ga});
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    w_rvalid    = 1'b0;
    hold_resp   = 1'b0;
    redirect    = 1'b0;
    drop_cnt    = 0;
    pend_q.delete();
    exp_q.delete();
    hs_log.delete();
    gnt_log.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
    w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = '0; w_ready = 1'b1; w_redirect = 1'b0; w_target = '0;
    hold_resp = 1'b0; drop_cnt = 0;
    #12;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_flushed", perf_flushed, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sequential fetch, always granted, always ready.
    tick();
    chk("s1_req_after_idle", 32'(imem_req), 1);
    tick();
    chk("s1_no_early_valid", 32'(instr_valid), 0);
    tick();
    chk("s1_valid_latency", 32'(instr_valid), 1);
    for (int i = 0; i < 40 && hs_log.size() < 3; i++) tick();
    chk("s1_hs_count", 32'(hs_log.size() >= 3), 1);
    chk("s1_gnt_count", 32'(gnt_log.size() >= 3), 1);
    if (hs_log.size() >= 3 && gnt_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("s1_gnt_addr", gnt_log[i], 32'(4 * i));
        chk("s1_hs_pc", hs_log[i], 32'(4 * i));
      end
    end

    // Wrap-around instance started from 0xFFFF_FFF8.
    chk("s5_wrap_count", 32'(w_log.size()), 3);
    if (w_log.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("s5_wrap_addr", w_log[i], wexp[i]);
    end

    // Downstream stalled: buffer fills, requests stop, then drain and resume.
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    chk("s2_req_stalled", 32'(imem_req), 0);
    chk("s2_valid_held", 32'(instr_valid), 1);
    chk("s2_head_pc", instr_pc, 32'h0);
    chk("s2_gnt_count", 32'(gnt_log.size()), 2);
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && (hs_log.size() < 2 || gnt_log.size() < 3); i++) tick();
    if (hs_log.size() >= 2 && gnt_log.size() >= 3) begin
      chk("s2_drain0", hs_log[0], 32'h0);
      chk("s2_drain1", hs_log[1], 32'h4);
      chk("s2_resume", gnt_log[2], 32'h8);
    end else begin
      chk("s2_drain_progress", 32'(hs_log.size() >= 2 && gnt_log.size() >= 3), 1);
    end

    // Redirect while waiting on the response for 0x8.
    do_reset();
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h8); i++) tick();
    chk("s3_reach_8", 32'(imem_req && imem_addr == 32'h8), 1);
    hold_resp = 1'b1;
    tick();
    redirect = 1'b1; redirect_target = 32'h103; hs_log.delete();
    tick();
    redirect = 1'b0;
    chk("s3_kill_no_req", 32'(imem_req), 0);
    hold_resp = 1'b0;
    tick();
    tick();
    chk("s3_new_req", 32'(imem_req), 1);
    chk("s3_new_addr", imem_addr, 32'h100);
    for (int i = 0; i < 20 && hs_log.size() < 2; i++) tick();
    chk("s3_hs_count", 32'(hs_log.size() >= 2), 1);
    if (hs_log.size() >= 2) begin
      chk("s3_first_pc", hs_log[0], 32'h100);
      chk("s3_second_pc", hs_log[1], 32'h104);
    end
    n = 0;
    foreach (hs_log[i]) if (hs_log[i] == 32'h8) n++;
    chk("s3_no_pc8", 32'(n), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("s3_perf_flushed_ge2", 32'(perf_flushed >= 32'd2), 1);
`endif

    // Redirect coinciding with a pop and an rvalid.
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !(imem_rvalid && instr_valid); i++) tick();
    chk("s4_setup", 32'(imem_rvalid && instr_valid), 1);
    instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h200; hs_log.delete();
    tick();
    redirect = 1'b0;
    chk("s4_valid_cleared", 32'(instr_valid), 0);
    chk("s4_no_hs", 32'(hs_log.size()), 0);
    chk("s4_req", 32'(imem_req), 1);
    chk("s4_addr", imem_addr, 32'h200);
    for (int i = 0; i < 20 && hs_log.size() < 1; i++) tick();
    if (hs_log.size() >= 1) chk("s4_first_pc", hs_log[0], 32'h200);
    else chk("s4_hs_progress", 32'(hs_log.size()), 1);

    // Asynchronous reset while a response is outstanding.
    instr_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    chk("s6_buffered", 32'(instr_valid), 1);
    hold_resp = 1'b1;
    tick();
    chk("s6_in_wait", 32'(imem_req), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_req", 32'(imem_req), 0);
    chk("s6_rst_addr", imem_addr, 32'h0);
    chk("s6_rst_valid", 32'(instr_valid), 0);
    chk("s6_rst_instr", instr, 0);
    chk("s6_rst_pc", instr_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("s6_perf_fetched", perf_fetched, 0);
    chk("s6_perf_flushed", perf_flushed, 0);
`endif
    instr_ready = 1'b1;
    do_reset();
    tick();
    chk("s6_restart_req", 32'(imem_req), 1);
    chk("s6_restart_addr", imem_addr, 32'h0);
    for (int i = 0; i < 20 && hs_log.size() < 1; i++) tick();
    if (hs_log.size() >= 1) chk("s6_restart_pc", hs_log[0], 32'h0);
    else chk("s6_restart_progress", 32'(hs_log.size()), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
